// File: rtl/sample_delta_packer.sv
// sample_delta_packer
//
// Change-compressor for the signal sampler. Each accepted multi-channel sample
// is compared with the previous accepted sample. The block emits a frame made of
// a change bitmap and the changed channel words, packed from slot 0 upward.
// Keyframes come from reset, from kf_req, or every KF_INTERVAL accepted samples.
// If SUPPRESS_IDLE is set, samples with no change are dropped and counted. A
// heartbeat frame is emitted when that count reaches its maximum.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_valid     data_in carries a sample this cycle
//   data_in      CHANNEL words of DATA_BITS; channel j at [DATA_BITS*(j+1)-1 : DATA_BITS*j]
//   kf_req       single-cycle keyframe request
//   chan_mask    1 = channel participates (sampled with in_valid)
//   out_valid    one-cycle frame strobe
//   out_keyframe frame is a keyframe
//   out_bitmap   bit j = channel j included in the frame
//   out_count    popcount of out_bitmap
//   out_data     included words packed from slot 0 upward; unused slots zero
//   out_skip     samples suppressed since the previous emitted frame
//   out_original unmodified sample that produced the frame
//
// Latency: CHANNEL+1 register stages (stage 0 decision + one packing stage
// per channel). Fully pipelined. All out_* hold the last frame while
// out_valid is low.

module sample_delta_packer #(
    parameter int unsigned CHANNEL       = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned KF_INTERVAL   = 1024,
    parameter int unsigned SKIP_BITS     = 8,
    parameter int unsigned SUPPRESS_IDLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_BITS*CHANNEL-1:0]  data_in,
    input  logic                          kf_req,
    input  logic [CHANNEL-1:0]            chan_mask,
    output logic                          out_valid,
    output logic                          out_keyframe,
    output logic [CHANNEL-1:0]            out_bitmap,
    output logic [$clog2(CHANNEL+1)-1:0]  out_count,
    output logic [DATA_BITS*CHANNEL-1:0]  out_data,
    output logic [SKIP_BITS-1:0]          out_skip,
    output logic [DATA_BITS*CHANNEL-1:0]  out_original
);

    localparam int unsigned W  = DATA_BITS * CHANNEL;
    localparam int unsigned CW = $clog2(CHANNEL + 1);
    localparam int unsigned IW = (KF_INTERVAL > 1) ? $clog2(KF_INTERVAL) : 1;
    localparam logic [IW-1:0] INT_LAST = IW'((KF_INTERVAL > 0) ? KF_INTERVAL - 1 : 0);

    // ------------------------------------------------------------------
    // Stage 0 state: reference sample, keyframe bookkeeping, skip counter
    // ------------------------------------------------------------------
    logic [W-1:0]         stored;
    logic                 kf_pending;
    logic [IW-1:0]        int_cnt;
    logic [SKIP_BITS-1:0] skip_cnt;

    logic [CHANNEL-1:0]   raw_bitmap;
    logic                 interval_hit;
    logic                 heartbeat;
    logic                 kf_now;
    logic                 emit;

    always_comb begin
        raw_bitmap = '0;
        for (int unsigned j = 0; j < CHANNEL; j++) begin
            raw_bitmap[j] = chan_mask[j] &&
                (data_in[j*DATA_BITS +: DATA_BITS] != stored[j*DATA_BITS +: DATA_BITS]);
        end
    end

    always_comb begin
        interval_hit = (KF_INTERVAL != 0) && (int_cnt == INT_LAST);
        kf_now       = kf_pending || kf_req || interval_hit;
        // The heartbeat fires at the saturation value, so the skip counter
        // never has to clamp.
        heartbeat    = (skip_cnt == '1);
        emit         = kf_now || (raw_bitmap != '0) || (SUPPRESS_IDLE == 0) || heartbeat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored     <= '0;
            kf_pending <= 1'b1;
            int_cnt    <= '0;
            skip_cnt   <= '0;
        end else if (in_valid) begin
            // Reference tracks every accepted sample, masked or suppressed.
            stored     <= data_in;
            kf_pending <= 1'b0;
            int_cnt    <= kf_now ? '0 : int_cnt + 1'b1;
            skip_cnt   <= emit ? '0 : skip_cnt + 1'b1;
        end else if (kf_req) begin
            // A request without a sample is deferred to the next valid.
            kf_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: index 0 = stage 0 output, index k+1 = after packing channel k
    // ------------------------------------------------------------------
    logic [CHANNEL:0]                 st_valid;
    logic [CHANNEL:0]                 st_key;
    logic [CHANNEL:0][CHANNEL-1:0]    st_bitmap;
    logic [CHANNEL:0][CW-1:0]         st_count;
    logic [CHANNEL:0][W-1:0]          st_data;
    logic [CHANNEL:0][SKIP_BITS-1:0]  st_skip;
    logic [CHANNEL:0][W-1:0]          st_orig;

    logic [CHANNEL-1:0][W-1:0]        pk_data;
    logic [CHANNEL-1:0][CW-1:0]       pk_count;

    // Packing stage k drops channel k's word into the slot indexed by the
    // running count, which is the next free slot.
    always_comb begin
        pk_data  = '0;
        pk_count = '0;
        for (int unsigned k = 0; k < CHANNEL; k++) begin
            pk_data[k]  = st_data[k];
            pk_count[k] = st_count[k];
            if (st_bitmap[k][k]) begin
                for (int unsigned s = 0; s < CHANNEL; s++) begin
                    if (CW'(s) == st_count[k]) begin
                        pk_data[k][s*DATA_BITS +: DATA_BITS] = st_orig[k][k*DATA_BITS +: DATA_BITS];
                    end
                end
                pk_count[k] = st_count[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid  <= '0;
            st_key    <= '0;
            st_bitmap <= '0;
            st_count  <= '0;
            st_data   <= '0;
            st_skip   <= '0;
            st_orig   <= '0;
        end else begin
            st_valid[0] <= in_valid && emit;
            if (in_valid && emit) begin
                st_key[0]    <= kf_now;
                st_bitmap[0] <= kf_now ? chan_mask : raw_bitmap;
                st_count[0]  <= '0;
                st_data[0]   <= '0;
                st_skip[0]   <= skip_cnt;
                st_orig[0]   <= data_in;
            end
            // Fields advance only with a valid frame, so every stage (and the
            // outputs) holds its last frame across bubbles.
            for (int unsigned k = 0; k < CHANNEL; k++) begin
                st_valid[k+1] <= st_valid[k];
                if (st_valid[k]) begin
                    st_key[k+1]    <= st_key[k];
                    st_bitmap[k+1] <= st_bitmap[k];
                    st_count[k+1]  <= pk_count[k];
                    st_data[k+1]   <= pk_data[k];
                    st_skip[k+1]   <= st_skip[k];
                    st_orig[k+1]   <= st_orig[k];
                end
            end
        end
    end

    assign out_valid    = st_valid[CHANNEL];
    assign out_keyframe = st_key[CHANNEL];
    assign out_bitmap   = st_bitmap[CHANNEL];
    assign out_count    = st_count[CHANNEL];
    assign out_data     = st_data[CHANNEL];
    assign out_skip     = st_skip[CHANNEL];
    assign out_original = st_orig[CHANNEL];

endmodule

// File: tb/tb_sample_delta_packer.sv
// tb_sample_delta_packer
//
// Directed bench for sample_delta_packer with CHANNEL=4, DATA_BITS=8.
// dut_a: no periodic keyframes, SKIP_BITS=3 (heartbeat every 8th idle valid).
// dut_b: KF_INTERVAL=4, SKIP_BITS=8.
// Both instances share the inputs. Each phase checks one instance. Frames
// are captured on the falling edge into per-instance queues and are then
// compared with hand-computed values.

module tb_sample_delta_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        kf_req = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  chan_mask = '0;

    logic        a_valid, a_key;
    logic [3:0]  a_bitmap;
    logic [2:0]  a_count;
    logic [31:0] a_data, a_orig;
    logic [2:0]  a_skip;

    logic        b_valid, b_key;
    logic [3:0]  b_bitmap;
    logic [2:0]  b_count;
    logic [31:0] b_data, b_orig;
    logic [7:0]  b_skip;

    sample_delta_packer #(
        .CHANNEL(4), .DATA_BITS(8), .KF_INTERVAL(0), .SKIP_BITS(3), .SUPPRESS_IDLE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .kf_req(kf_req), .chan_mask(chan_mask),
        .out_valid(a_valid), .out_keyframe(a_key), .out_bitmap(a_bitmap),
        .out_count(a_count), .out_data(a_data), .out_skip(a_skip),
        .out_original(a_orig)
    );

    sample_delta_packer #(
        .CHANNEL(4), .DATA_BITS(8), .KF_INTERVAL(4), .SKIP_BITS(8), .SUPPRESS_IDLE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .kf_req(kf_req), .chan_mask(chan_mask),
        .out_valid(b_valid), .out_keyframe(b_key), .out_bitmap(b_bitmap),
        .out_count(b_count), .out_data(b_data), .out_skip(b_skip),
        .out_original(b_orig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        key;
        logic [3:0]  bitmap;
        logic [2:0]  count;
        logic [31:0] data;
        logic [7:0]  skip;
        logic [31:0] orig;
        int          stamp;
    } frame_t;

    frame_t qa[$];
    frame_t qb[$];

    // The stamp is the edge at which a downstream consumer would capture the frame.
    always @(negedge clk) begin
        frame_t f;
        if (a_valid) begin
            f.key = a_key; f.bitmap = a_bitmap; f.count = a_count; f.data = a_data;
            f.skip = {5'd0, a_skip}; f.orig = a_orig; f.stamp = cyc + 1;
            qa.push_back(f);
        end
        if (b_valid) begin
            f.key = b_key; f.bitmap = b_bitmap; f.count = b_count; f.data = b_data;
            f.skip = b_skip; f.orig = b_orig; f.stamp = cyc + 1;
            qb.push_back(f);
        end
    end

    int checks = 0;
    int errors = 0;
    int last_edge = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic k, input logic [3:0] m);
        in_valid  = v;
        data_in   = d;
        kf_req    = k;
        chan_mask = m;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        kf_req    = 1'b0;
        last_edge = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, data_in, 1'b0, chan_mask);
    endtask

    // stamp = edge that sampled the input; 0 skips the latency comparison
    task automatic expect_frame(input bit from_b, input string tag, input logic key,
                                input logic [3:0] bm, input logic [2:0] cnt,
                                input logic [31:0] data, input logic [7:0] skip,
                                input logic [31:0] orig, input int stamp);
        frame_t f;
        int n;
        n = from_b ? qb.size() : qa.size();
        chk({tag, ".present"}, 64'(n != 0), 64'd1);
        if (n == 0) return;
        if (from_b) f = qb.pop_front();
        else        f = qa.pop_front();
        chk({tag, ".key"},    64'(f.key),    64'(key));
        chk({tag, ".bitmap"}, 64'(f.bitmap), 64'(bm));
        chk({tag, ".count"},  64'(f.count),  64'(cnt));
        chk({tag, ".data"},   64'(f.data),   64'(data));
        chk({tag, ".skip"},   64'(f.skip),   64'(skip));
        chk({tag, ".orig"},   64'(f.orig),   64'(orig));
        if (stamp != 0) chk({tag, ".latency"}, 64'(f.stamp - stamp), 64'd5);
    endtask

    task automatic expect_empty(input bit from_b, input string tag);
        chk(tag, 64'(from_b ? qb.size() : qa.size()), 64'd0);
    endtask

    initial begin
        int e1, e3, eh1, eh2, ek1, ek2, em1, em2, em3, ep1, ep2, er;
        int eb[9];
        logic [31:0] w;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a_valid", 64'(a_valid), 64'd0);
        chk("rst.a_ctl",   64'({a_key, a_bitmap, a_count, a_skip}), 64'd0);
        chk("rst.a_data",  64'(a_data), 64'd0);
        chk("rst.a_orig",  64'(a_orig), 64'd0);
        chk("rst.b_valid", 64'(b_valid), 64'd0);
        chk("rst.b_data",  64'({b_data, b_skip}), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Phase 1: keyframe, suppressed repeat, single-channel change
        drive(1'b1, 32'h04030201, 1'b0, 4'hF); e1 = last_edge;
        drive(1'b1, 32'h04030201, 1'b0, 4'hF);
        drive(1'b1, 32'h04990201, 1'b0, 4'hF); e3 = last_edge;
        idle(8);
        expect_frame(0, "p1.f1", 1'b1, 4'hF, 3'd4, 32'h04030201, 8'd0, 32'h04030201, e1);
        expect_frame(0, "p1.f3", 1'b0, 4'h4, 3'd1, 32'h00000099, 8'd1, 32'h04990201, e3);
        expect_empty(0, "p1.no_extra");
        chk("p1.hold_valid",  64'(a_valid),  64'd0);
        chk("p1.hold_bitmap", 64'(a_bitmap), 64'h4);
        chk("p1.hold_count",  64'(a_count),  64'd1);
        chk("p1.hold_data",   64'(a_data),   64'h99);
        chk("p1.hold_skip",   64'(a_skip),   64'd1);

        // Phase 2: idle stream -> heartbeat on every 8th valid
        eh1 = 0; eh2 = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h04990201, 1'b0, 4'hF);
            if (i == 7)  eh1 = last_edge;
            if (i == 15) eh2 = last_edge;
            if (i % 3 == 0) idle(1);
        end
        idle(8);
        expect_frame(0, "p2.hb1", 1'b0, 4'h0, 3'd0, 32'h0, 8'd7, 32'h04990201, eh1);
        expect_frame(0, "p2.hb2", 1'b0, 4'h0, 3'd0, 32'h0, 8'd7, 32'h04990201, eh2);
        expect_empty(0, "p2.no_extra");

        // Phase 3: kf_req while idle; kf_req coinciding with heartbeat
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h04990201, 1'b0, 4'hF);
        drive(1'b0, 32'h04990201, 1'b1, 4'hF);
        idle(2);
        drive(1'b1, 32'h04990201, 1'b0, 4'hF); ek1 = last_edge;
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h04990201, 1'b0, 4'hF);
        drive(1'b1, 32'h04990201, 1'b1, 4'hF); ek2 = last_edge;
        idle(8);
        expect_frame(0, "p3.kf_idle", 1'b1, 4'hF, 3'd4, 32'h04990201, 8'd3, 32'h04990201, ek1);
        expect_frame(0, "p3.kf_hb",   1'b1, 4'hF, 3'd4, 32'h04990201, 8'd7, 32'h04990201, ek2);
        expect_empty(0, "p3.no_extra");

        // Phase 4: channel masking, masked-channel reference update, mask-0 keyframe
        drive(1'b1, 32'h44332211, 1'b0, 4'h5); em1 = last_edge;
        drive(1'b1, 32'h44335511, 1'b0, 4'h5);
        drive(1'b1, 32'h44335511, 1'b0, 4'hF);
        drive(1'b1, 32'h55335511, 1'b0, 4'hF); em2 = last_edge;
        drive(1'b1, 32'h55335511, 1'b1, 4'h0); em3 = last_edge;
        idle(8);
        expect_frame(0, "p4.mask5", 1'b0, 4'h5, 3'd2, 32'h00003311, 8'd0, 32'h44332211, em1);
        expect_frame(0, "p4.ch3",   1'b0, 4'h8, 3'd1, 32'h00000055, 8'd2, 32'h55335511, em2);
        expect_frame(0, "p4.kf_m0", 1'b1, 4'h0, 3'd0, 32'h00000000, 8'd0, 32'h55335511, em3);
        expect_empty(0, "p4.no_extra");

        // Phase 5: periodic keyframes on dut_b, channel 1 changing
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        qa.delete();
        qb.delete();
        for (int i = 0; i < 9; i++) begin
            w = 32'h04031001 + 32'(i << 8);
            drive(1'b1, w, 1'b0, 4'hF);
            eb[i] = last_edge;
        end
        idle(8);
        for (int i = 0; i < 9; i++) begin
            w = 32'h04031001 + 32'(i << 8);
            if (i % 4 == 0)
                expect_frame(1, $sformatf("p5.kf%0d", i), 1'b1, 4'hF, 3'd4, w, 8'd0, w, eb[i]);
            else
                expect_frame(1, $sformatf("p5.d%0d", i), 1'b0, 4'h2, 3'd1, {24'd0, w[15:8]}, 8'd0, w, eb[i]);
        end
        expect_empty(1, "p5.no_extra");

        // Phase 6: reset with frames in flight
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        qa.delete();
        qb.delete();
        drive(1'b1, 32'hAAAAAAAA, 1'b0, 4'hF); ep1 = last_edge;
        drive(1'b1, 32'h55555555, 1'b0, 4'hF); ep2 = last_edge;
        for (int i = 2; i < 6; i++)
            drive(1'b1, (i % 2 == 1) ? 32'h55555555 : 32'hAAAAAAAA, 1'b0, 4'hF);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("p6.rst_valid",  64'(a_valid), 64'd0);
        chk("p6.rst_ctl",    64'({a_key, a_bitmap, a_count, a_skip}), 64'd0);
        chk("p6.rst_data",   64'(a_data), 64'd0);
        chk("p6.rst_orig",   64'(a_orig), 64'd0);
        idle(2);
        expect_frame(0, "p6.pre1", 1'b1, 4'hF, 3'd4, 32'hAAAAAAAA, 8'd0, 32'hAAAAAAAA, ep1);
        expect_frame(0, "p6.pre2", 1'b0, 4'hF, 3'd4, 32'h55555555, 8'd0, 32'h55555555, ep2);
        expect_empty(0, "p6.cut_at_reset");
        rst_n = 1'b1;
        idle(10);
        expect_empty(0, "p6.no_stale");
        drive(1'b1, 32'h55555555, 1'b0, 4'hF); er = last_edge;
        idle(8);
        expect_frame(0, "p6.post_kf", 1'b1, 4'hF, 3'd4, 32'h55555555, 8'd0, 32'h55555555, er);
        expect_empty(0, "p6.no_extra");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_delta_packer.md
Name: sample_delta_packer

Overview:
- Parametrised next-generation change-compressor for the signal sampler.
- Each valid multi-channel sample is compared against the previous valid sample. The block emits a change bitmap plus the changed channel words, packed contiguously.
- Adds a valid qualifier, keyframe request and periodic keyframes, channel masking, idle-sample suppression with a skip count, and heartbeat frames.
- Sits between the sample capture front-end and the transfer/FIFO packer.

Parameters:
CHANNEL, 8, number of channels (1..32)
DATA_BITS, 16, bits per channel word
KF_INTERVAL, 1024, force a keyframe every KF_INTERVAL accepted samples; 0 disables
SKIP_BITS, 8, width of the suppressed-sample counter
SUPPRESS_IDLE, 1, 1: drop frames with no change; 0: emit every sample

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  data_in holds a sample this cycle
data_in  in  DATA_BITS*CHANNEL  channel j at bits [DATA_BITS*(j+1)-1 : DATA_BITS*j]
kf_req  in  1  single-cycle keyframe request pulse
chan_mask  in  CHANNEL  1 = channel participates; sampled with in_valid
out_valid  out  1  output frame valid, one cycle per frame
out_keyframe  out  1  frame is a keyframe
out_bitmap  out  CHANNEL  bit j = channel j included
out_count  out  $clog2(CHANNEL+1)  popcount of out_bitmap
out_data  out  DATA_BITS*CHANNEL  packed changed words; unused slots zero
out_skip  out  SKIP_BITS  suppressed samples since the previous emitted frame
out_original  out  DATA_BITS*CHANNEL  unmodified sample, aligned with the frame

Behaviour:
- Reset: all outputs 0; pipeline valids 0; stored sample 0; kf_pending=1; interval counter 0; skip counter 0.
- Stage 0 acts on each cycle with in_valid=1; cycles with in_valid=0 are ignored entirely.
  - Keyframe condition: kf_pending, or kf_req in the same cycle, or (KF_INTERVAL!=0 and interval counter==KF_INTERVAL-1).
  - Raw bitmap: bit j = chan_mask[j] & (data_in word j != stored word j).
  - Keyframe bitmap: chan_mask, i.e. every unmasked channel. A keyframe with chan_mask=0 is still emitted, with bitmap 0.
  - Emit condition: keyframe, or raw bitmap != 0, or SUPPRESS_IDLE==0, or skip counter == 2^SKIP_BITS-1 (heartbeat, bitmap 0).
  - Emitted: frame enters the pipeline with skip = current skip counter; skip counter cleared.
  - Not emitted: pipeline bubble; skip counter incremented. Saturation cannot be exceeded because the heartbeat fires at max.
  - The stored sample updates to data_in on every valid, including masked channels and suppressed samples.
  - Interval counter resets to 0 on a keyframe, otherwise increments.
  - kf_pending clears on the first valid after reset.
  - kf_req while in_valid=0 sets kf_pending, so the next valid becomes a keyframe.
- Packing stages: CHANNEL registered stages. Stage k appends channel k's word to the next free slot if bitmap[k] is set.
  - Result: lowest-index included channel sits in slot 0 (bits DATA_BITS-1:0), ascending order.
  - Slots at out_count and above are zero.
- Latency: exactly CHANNEL+1 cycles from the in_valid edge to out_valid.
  - Fully pipelined: one sample accepted per cycle, no backpressure, frame order preserved.
  - All out_* fields are registered together with out_valid; they hold the last frame while out_valid=0.
- Simultaneous kf_req and a heartbeat: emitted as a keyframe (out_keyframe=1, full mask bitmap), with skip reported.
- Reset mid-stream: in-flight frames are discarded; the first valid after reset is a keyframe.

Test Plan:
- CHANNEL=4, DATA_BITS=8, chan_mask=F. Reset, then valid samples 0x04030201, 0x04030201, 0x04990201 -> frame1: keyframe, bitmap F, data 0x04030201, count 4. Sample 2 suppressed. Frame3: bitmap 4, count 1, data 0x00000099, skip 1. Each frame appears 5 cycles after its input.
- Idle stream, SKIP_BITS=3, constant data after the keyframe -> a heartbeat frame every 8th valid: bitmap 0, skip 7, keyframe 0.
- KF_INTERVAL=4, data changing only on channel 1 -> every 4th valid frame has keyframe=1 and bitmap F; the others have bitmap 2.
- kf_req pulsed during in_valid=0, then the next valid with unchanged data -> keyframe with bitmap F and skip equal to the idle count.
- chan_mask=5, all channels change -> bitmap 5, count 2, data = {ch2, ch0} in slots 1:0, slots 3:2 zero.
- Back-to-back valids with alternating data, then rst_n asserted mid-pipeline -> outputs 0 immediately; the first post-reset valid produces a keyframe; no stale frames.
